// File: rtl/fft8_stream_core.sv
// fft8_stream_core: streaming 8-point radix-2 DIT FFT, computed in place one butterfly per cycle.
// Optional FFT_SCALE_EN halves every butterfly output, so the bins come out as X/8.
module fft8_stream_core #(
  parameter int IN_W    = 8,
  parameter int TW_FRAC = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W+3:0] out_re,
  output logic signed [IN_W+3:0] out_im,
  output logic [2:0]             out_idx,
  output logic                   out_last,
  output logic                   busy
);
  // state | meaning
  // LOAD  | accept 8 samples into bit-reversed addresses
  // CALC  | 12 butterflies: 3 stages x 4, one per cycle
  // OUT   | present bins 0..7 in natural order under out_ready
  localparam int OUT_W = IN_W + 4;
  localparam int PW    = OUT_W + TW_FRAC + 3;
  localparam int C     = $rtoi(0.70710678 * (2.0 ** TW_FRAC) + 0.5);
  localparam logic signed [PW-1:0] C_P = PW'(C);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t state, state_nxt;
  logic [2:0] in_cnt, idx;
  logic [3:0] bf_cnt;
  logic signed [OUT_W-1:0] mem_re [0:7];
  logic signed [OUT_W-1:0] mem_im [0:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LOAD;
      in_cnt <= '0;
      bf_cnt <= '0;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD && in_valid) in_cnt <= in_cnt + 3'd1;
      if (state == S_CALC) bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
      if (state == S_OUT && out_ready) idx <= idx + 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (in_valid && in_cnt == 3'd7) state_nxt = S_CALC;
      S_CALC:  if (bf_cnt == 4'd11) state_nxt = S_OUT;
      S_OUT:   if (out_ready && idx == 3'd7) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_LOAD);
    busy      = (state != S_LOAD);
    out_valid = (state == S_OUT);
    out_idx   = idx;
    out_last  = (state == S_OUT) && (idx == 3'd7);
    out_re    = (state == S_OUT) ? mem_re[idx] : '0;
    out_im    = (state == S_OUT) ? mem_im[idx] : '0;
  end

  // Butterfly addressing: stage in bf_cnt[3:2], butterfly in bf_cnt[1:0].
  logic [1:0] stg, bf, tw_k;
  logic [2:0] p_addr, q_addr;
  assign stg = bf_cnt[3:2];
  assign bf  = bf_cnt[1:0];

  always_comb begin
    p_addr = '0;
    q_addr = '0;
    tw_k   = '0;
    case (stg)
      2'd0: begin
        p_addr = {bf, 1'b0};
        q_addr = {bf, 1'b1};
        tw_k   = 2'd0;
      end
      2'd1: begin
        p_addr = {bf[1], 1'b0, bf[0]};
        q_addr = {bf[1], 1'b1, bf[0]};
        tw_k   = {bf[0], 1'b0};
      end
      default: begin
        p_addr = {1'b0, bf};
        q_addr = {1'b1, bf};
        tw_k   = bf;
      end
    endcase
  end

  logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [PW-1:0]    br_x, bi_x, wr, wi, pr, pi;
  logic signed [OUT_W:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [OUT_W-1:0] wp_re, wp_im, wq_re, wq_im;

  always_comb begin
    a_re = mem_re[p_addr];
    a_im = mem_im[p_addr];
    b_re = mem_re[q_addr];
    b_im = mem_im[q_addr];
    br_x = PW'(b_re);
    bi_x = PW'(b_im);
    wr   = (tw_k == 2'd1) ? C_P : -C_P;
    wi   = -C_P;
    pr   = br_x * wr - bi_x * wi;
    pi   = br_x * wi + bi_x * wr;
    case (tw_k)
      2'd0: begin
        t_re = b_re;
        t_im = b_im;
      end
      2'd2: begin
        t_re = b_im;
        t_im = -b_re;
      end
      default: begin
        t_re = OUT_W'(pr >>> TW_FRAC);
        t_im = OUT_W'(pi >>> TW_FRAC);
      end
    endcase
    sum_re = (OUT_W+1)'(a_re) + (OUT_W+1)'(t_re);
    sum_im = (OUT_W+1)'(a_im) + (OUT_W+1)'(t_im);
    dif_re = (OUT_W+1)'(a_re) - (OUT_W+1)'(t_re);
    dif_im = (OUT_W+1)'(a_im) - (OUT_W+1)'(t_im);
`ifdef FFT_SCALE_EN
    wp_re = OUT_W'(sum_re >>> 1);
    wp_im = OUT_W'(sum_im >>> 1);
    wq_re = OUT_W'(dif_re >>> 1);
    wq_im = OUT_W'(dif_im >>> 1);
`else
    wp_re = OUT_W'(sum_re);
    wp_im = OUT_W'(sum_im);
    wq_re = OUT_W'(dif_re);
    wq_im = OUT_W'(dif_im);
`endif
  end

  // Memory has no reset; a restarted frame overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_LOAD && in_valid) begin
        mem_re[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= OUT_W'(in_re);
        mem_im[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= OUT_W'(in_im);
      end else if (state == S_CALC) begin
        mem_re[p_addr] <= wp_re;
        mem_im[p_addr] <= wp_im;
        mem_re[q_addr] <= wq_re;
        mem_im[q_addr] <= wq_im;
      end
    end
  end

endmodule

// File: tb/tb_fft8_stream_core.sv
// Self-checking bench for fft8_stream_core: loop-based DIT reference model, one negedge compare process.
// Honours FFT_SCALE_EN when the same macro is defined for the bench.
module tb_fft8_stream_core;
  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W + 4;
  localparam int TWF   = 7;
  localparam int C     = 91;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [IN_W-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [OUT_W-1:0] out_re, out_im;
  logic [2:0] out_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {int re; int im; int idx;} bin_t;
  bin_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft8_stream_core #(.IN_W(IN_W), .TW_FRAC(TWF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Reference: textbook in-place DIT with the fixed-point twiddle rules.
  function automatic void fft_model(input int xr[8], input int xi[8],
                                    output int yr[8], output int yi[8]);
    int ar[8], ai[8];
    for (int n = 0; n < 8; n++) begin
      ar[brev(n)] = xr[n];
      ai[brev(n)] = xi[n];
    end
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++) begin
        int span, g, j, p, q, k, tr, ti, wr, wi, sr, si, dr, di;
        span = 1 << s;
        g = b / span;
        j = b % span;
        p = g * 2 * span + j;
        q = p + span;
        k = j * (4 / span);
        if (k == 0) begin
          tr = ar[q]; ti = ai[q];
        end else if (k == 2) begin
          tr = ai[q]; ti = -ar[q];
        end else begin
          wr = (k == 1) ? C : -C;
          wi = -C;
          tr = (ar[q] * wr - ai[q] * wi) >>> TWF;
          ti = (ar[q] * wi + ai[q] * wr) >>> TWF;
        end
        sr = ar[p] + tr; si = ai[p] + ti;
        dr = ar[p] - tr; di = ai[p] - ti;
`ifdef FFT_SCALE_EN
        sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
`endif
        ar[p] = sr; ai[p] = si; ar[q] = dr; ai[q] = di;
      end
    end
    yr = ar;
    yi = ai;
  endfunction

  // Compare process: tracks transfers, builds expectations, checks every cycle.
  int  tcount = 0;
  bit  pending = 1'b0;
  int  acc_edge = 0;
  int  sxr[8], sxi[8];
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pending = 1'b0;
      tcount = 0;
    end else begin
      bit exp_ov;
      check_int("in_ready", int'(in_ready), int'(!pending));
      check_int("busy", int'(busy), int'(pending));
      exp_ov = pending && (cyc >= acc_edge + 12);
      check_int("out_valid", int'(out_valid), int'(exp_ov));
      if (out_valid && exp_q.size() > 0) begin
        bin_t e;
        e = exp_q[0];
        check_int("out_re", int'(out_re), e.re);
        check_int("out_im", int'(out_im), e.im);
        check_int("out_idx", int'(out_idx), e.idx);
        check_int("out_last", int'(out_last), int'(e.idx == 7));
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.idx == 7) pending = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        sxr[tcount] = int'(in_re);
        sxi[tcount] = int'(in_im);
        tcount++;
        if (tcount == 8) begin
          int yr[8], yi[8];
          fft_model(sxr, sxi, yr, yi);
          for (int k = 0; k < 8; k++) exp_q.push_back('{re: yr[k], im: yi[k], idx: k});
          pending = 1'b1;
          acc_edge = cyc + 1;
          tcount = 0;
        end
      end
    end
  end

  task automatic send_frame(input int xr[8], input int xi[8], input bit gaps);
    int n = 0;
    int budget = 0;
    bit fire;
    while (n < 8 && budget < 200) begin
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_re = IN_W'(xr[n]);
      in_im = IN_W'(xi[n]);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) n++;
      budget++;
    end
    in_valid = 1'b0;
    check_int("send_done", n, 8);
  endtask

  // bp_mode: 0 always ready, 1 random ready, 2 stall 3 cycles at bin 3.
  task automatic wait_done(input int bp_mode);
    int budget = 0;
    int hold = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      in_valid = $urandom_range(1);
      in_re = IN_W'($urandom_range(255));
      in_im = IN_W'($urandom_range(255));
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = $urandom_range(1);
        default: begin
          if (out_valid && out_idx == 3'd3 && hold < 3) begin
            out_ready = 1'b0;
            hold++;
          end else out_ready = 1'b1;
        end
      endcase
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_int("frame_drained", exp_q.size(), 0);
    if (bp_mode == 2) check_int("bp_stall_cycles", hold, 3);
  endtask

  task automatic rand_frame(output int xr[8], output int xi[8]);
    for (int n = 0; n < 8; n++) begin
      xr[n] = int'($urandom_range(255)) - 128;
      xi[n] = int'($urandom_range(255)) - 128;
    end
  endtask

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int xr[8], xi[8], yr[8], yi[8];
    int t4r[8], t4i[8];

    // Pin the model with hand-computed results.
    xr = '{100, 0, 0, 0, 0, 0, 0, 0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    fft_model(xr, xi, yr, yi);
`ifdef FFT_SCALE_EN
    check_int("pin_impulse_b5_re", yr[5], 12);
`else
    check_int("pin_impulse_b5_re", yr[5], 100);
`endif
    check_int("pin_impulse_b5_im", yi[5], 0);
`ifndef FFT_SCALE_EN
    xr = '{10, 10, 10, 10, 10, 10, 10, 10};
    fft_model(xr, xi, yr, yi);
    check_int("pin_dc_b0", yr[0], 80);
    check_int("pin_dc_b3", yr[3], 0);
    xr = '{50, -50, 50, -50, 50, -50, 50, -50};
    fft_model(xr, xi, yr, yi);
    check_int("pin_alt_b4", yr[4], 400);
    check_int("pin_alt_b2", yr[2], 0);
    xr = '{0, 64, 0, 0, 0, 0, 0, 0};
    fft_model(xr, xi, yr, yi);
    t4r = '{64, 45, 0, -46, -64, -45, 0, 46};
    t4i = '{0, -46, -64, -46, 0, 46, 64, 46};
    for (int k = 0; k < 8; k++) begin
      check_int("pin_shift_re", yr[k], t4r[k]);
      check_int("pin_shift_im", yi[k], t4i[k]);
    end
`endif

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_out_idx", int'(out_idx), 0);
    check_int("reset_out_re", int'(out_re), 0);
    @(posedge clk);
    #1;

    xr = '{100, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 1'b0);
    wait_done(0);

    xr = '{10, 10, 10, 10, 10, 10, 10, 10};
    send_frame(xr, xi, 1'b0);
    wait_done(0);

    xr = '{50, -50, 50, -50, 50, -50, 50, -50};
    send_frame(xr, xi, 1'b1);
    wait_done(1);

    xr = '{0, 64, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 1'b0);
    wait_done(0);

    rand_frame(xr, xi);
    send_frame(xr, xi, 1'b1);
    wait_done(2);
    rand_frame(xr, xi);
    send_frame(xr, xi, 1'b0);
    wait_done(1);

    // Reset on the edge that would perform butterfly 6.
    xr = '{7, -3, 22, 90, -128, 127, 1, -1};
    xi = '{-5, 44, 0, -70, 3, 127, -128, 9};
    send_frame(xr, xi, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("midcalc_rst_out_valid", int'(out_valid), 0);
    check_int("midcalc_rst_busy", int'(busy), 0);
    check_int("midcalc_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    xr = '{10, 10, 10, 10, 10, 10, 10, 10};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xr, xi, 1'b0);
    wait_done(0);

    repeat (8) begin
      rand_frame(xr, xi);
      send_frame(xr, xi, 1'b1);
      wait_done(1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
